// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//
// Serial receive front end for the MIPS SoC. It brings the asynchronous RX
// pin into the clk domain through a two-flop synchronizer. It then recovers
// 8N1 frames by sampling each bit at its mid-point. Good bytes are presented
// to the core's UART receive registers with a sticky "byte available" flag,
// which the core acknowledges with a one-cycle clear.
//
// Parameters
//   CLK_FREQ     clk frequency in Hz
//   BAUD_RATE    line rate in bit/s
//   BIT_TICKS    clocks per bit (must be >= 4)
//   HALF_TICKS   clocks from the detected start edge to the start-bit middle
//
// Ports
//   clk          system clock, the only clock in the block
//   reset        asynchronous, active-low reset
//   SerialDataIn asynchronous RX line, idle high
//   rx_clear     one-cycle acknowledge; clears Rx_flag, overrun_err, frame_err
//   DataRx_out   last good received byte
//   Rx_flag      sticky "byte available"
//   frame_err    sticky "stop bit sampled low"
//   overrun_err  sticky "byte completed while Rx_flag was still set"
//   rx_busy      high whenever the receiver is not idle

module uart_rx_deserializer #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int BIT_TICKS  = CLK_FREQ / BAUD_RATE,
    parameter int HALF_TICKS = BIT_TICKS / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SerialDataIn,
    input  logic       rx_clear,
    output logic [7:0] DataRx_out,
    output logic       Rx_flag,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(BIT_TICKS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic             sync_ff1;
    logic             rx_s;
    logic             good_stop;
    logic             bad_stop;

    // Two-flop synchronizer on the RX pin. Both flops reset to the idle
    // (high) line level, so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff1 <= 1'b1;
            rx_s     <= 1'b1;
        end else begin
            sync_ff1 <= SerialDataIn;
            rx_s     <= sync_ff1;
        end
    end

    // Frame sequencer. The tick counter runs freely and is forced back to
    // zero on every state entry and after every sample. The sample in each
    // state therefore always lands on the same count. START waits only half
    // a bit, so every later sample falls in the middle of its bit. BREAK
    // absorbs a line that stays low after a bad stop bit. Without it, that
    // line would be taken as a fresh start bit.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CNT_ONE;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        good_stop    = 1'b0;
        bad_stop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        good_stop  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers. rx_busy is registered from the next
    // state, so it always matches the state register one-for-one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            rx_busy <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
            rx_busy <= (state_next != IDLE);
        end
    end

    // Sticky status toward the core. A completing byte takes priority over
    // an acknowledge that arrives in the same cycle. So does a bad stop bit.
    // This way the core never loses the fact that something new happened.
    // Overrun is only raised when the old byte was still unacknowledged.
    // The new byte overwrites the old one regardless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            DataRx_out  <= 8'h00;
            Rx_flag     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (good_stop) begin
                DataRx_out <= shreg;
                Rx_flag    <= 1'b1;
            end else if (rx_clear) begin
                Rx_flag <= 1'b0;
            end

            if (good_stop && Rx_flag && !rx_clear) begin
                overrun_err <= 1'b1;
            end else if (rx_clear) begin
                overrun_err <= 1'b0;
            end

            if (bad_stop) begin
                frame_err <= 1'b1;
            end else if (rx_clear) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
//
// Directed bench for uart_rx_deserializer with BIT_TICKS=16, HALF_TICKS=8.
// A timing-arithmetic reference model predicts every output from the history
// of line samples. A compare process checks the DUT against it on each
// falling clock edge outside reset. Hand-computed literal checks in the main
// sequence pin the absolute timing and values.

module tb_uart_rx_deserializer;

    localparam int B    = 16;
    localparam int H    = 8;
    localparam int HIST = 4096;

    logic       clk          = 1'b0;
    logic       reset        = 1'b0;
    logic       SerialDataIn = 1'b1;
    logic       rx_clear     = 1'b0;
    logic [7:0] DataRx_out;
    logic       Rx_flag;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state
    typedef enum {M_IDLE, M_FRAME, M_BREAK} model_mode_t;
    model_mode_t m_mode = M_IDLE;
    logic        hist [0:HIST-1];
    int          cyc    = 0;
    int          m_te   = 0;
    logic [7:0]  m_data = 8'h00;
    logic        m_flag = 1'b0;
    logic        m_ferr = 1'b0;
    logic        m_ovr  = 1'b0;
    logic        m_busy = 1'b0;

    int busy_cnt;

    uart_rx_deserializer #(
        .BIT_TICKS  (B),
        .HALF_TICKS (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .SerialDataIn (SerialDataIn),
        .rx_clear     (rx_clear),
        .DataRx_out   (DataRx_out),
        .Rx_flag      (Rx_flag),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err),
        .rx_busy      (rx_busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // One comparison: bumps the counters and reports any difference
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Hold a line level and clear level for a number of cycles, changing on negedges
    task automatic applyStimulus(input logic line, input logic clr, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            SerialDataIn = line;
            rx_clear     = clr;
        end
    endtask

    // Drive the first n_cyc cycles of an 8N1 frame; rx_clear pulses at cycle clr_at
    task automatic sendFrame(input logic [7:0] b, input logic stop_bit,
                             input int clr_at, input int n_cyc);
        for (int i = 0; i < n_cyc; i++) begin
            int   slot;
            logic line;
            slot = i / B;
            if (slot == 0)      line = 1'b0;
            else if (slot <= 8) line = b[slot-1];
            else                line = stop_bit;
            applyStimulus(line, (i == clr_at), 1);
        end
    endtask

    // Reference model. It logs what the line was at every clock edge and
    // treats reset as holding the line idle. A frame's te is the logged edge
    // of its first low sample. The model then reads the start, data and stop
    // samples straight out of the history at te+H+k*B.
    initial begin
        int         n;
        logic       good;
        logic       bad;
        logic       clr;
        logic [7:0] rx_byte;
        forever begin
            @(posedge clk);
            n = cyc;
            if (!reset) begin
                hist[n % HIST] = 1'b1;
                m_mode = M_IDLE;
                m_data = 8'h00;
                m_flag = 1'b0;
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end else begin
                hist[n % HIST] = SerialDataIn;
                clr     = rx_clear;
                good    = 1'b0;
                bad     = 1'b0;
                rx_byte = 8'h00;
                case (m_mode)
                    M_IDLE: begin
                        if (n >= 2 && hist[(n-2) % HIST] == 1'b0) begin
                            m_mode = M_FRAME;
                            m_te   = n - 2;
                        end
                    end
                    M_FRAME: begin
                        if (n == m_te + 2 + H && hist[(m_te + H) % HIST] == 1'b1) begin
                            m_mode = M_IDLE;
                        end else if (n == m_te + 2 + H + 9*B) begin
                            for (int k = 0; k < 8; k++) begin
                                rx_byte[k] = hist[(m_te + H + (k+1)*B) % HIST];
                            end
                            if (hist[(m_te + H + 9*B) % HIST]) begin
                                good   = 1'b1;
                                m_mode = M_IDLE;
                            end else begin
                                bad    = 1'b1;
                                m_mode = M_BREAK;
                            end
                        end
                    end
                    M_BREAK: begin
                        if (hist[(n-2) % HIST] == 1'b1) begin
                            m_mode = M_IDLE;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase

                if (good) begin
                    if (m_flag && !clr) m_ovr = 1'b1;
                    else if (clr)       m_ovr = 1'b0;
                    if (clr)            m_ferr = 1'b0;
                    m_flag = 1'b1;
                    m_data = rx_byte;
                end else if (bad) begin
                    m_ferr = 1'b1;
                    if (clr) begin
                        m_flag = 1'b0;
                        m_ovr  = 1'b0;
                    end
                end else if (clr) begin
                    m_flag = 1'b0;
                    m_ferr = 1'b0;
                    m_ovr  = 1'b0;
                end
            end
            m_busy = (m_mode != M_IDLE);
            cyc++;
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                checkOutput("model DataRx_out",  32'(DataRx_out),  32'(m_data));
                checkOutput("model Rx_flag",     32'(Rx_flag),     32'(m_flag));
                checkOutput("model frame_err",   32'(frame_err),   32'(m_ferr));
                checkOutput("model overrun_err", 32'(overrun_err), 32'(m_ovr));
                checkOutput("model rx_busy",     32'(rx_busy),     32'(m_busy));
            end
        end
    end

    // Directed sequence
    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        checkOutput("reset DataRx_out",  32'(DataRx_out),  32'h00);
        checkOutput("reset Rx_flag",     32'(Rx_flag),     32'h0);
        checkOutput("reset frame_err",   32'(frame_err),   32'h0);
        checkOutput("reset overrun_err", 32'(overrun_err), 32'h0);
        checkOutput("reset rx_busy",     32'(rx_busy),     32'h0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 10);

        // Good byte 0xA5 with exact timing relative to te
        fork
            sendFrame(8'hA5, 1'b1, -1, 10*B);
            begin
                repeat (3) @(negedge clk);
                checkOutput("A5 busy at te+2", 32'(rx_busy), 32'h0);
                @(negedge clk);
                checkOutput("A5 busy at te+3", 32'(rx_busy), 32'h1);
                repeat (151) @(negedge clk);
                checkOutput("A5 flag at te+154", 32'(Rx_flag), 32'h0);
                checkOutput("A5 busy at te+154", 32'(rx_busy), 32'h1);
                @(negedge clk);
                checkOutput("A5 flag at te+155", 32'(Rx_flag),    32'h1);
                checkOutput("A5 data at te+155", 32'(DataRx_out), 32'hA5);
                checkOutput("A5 busy at te+155", 32'(rx_busy),    32'h0);
                checkOutput("A5 frame_err",      32'(frame_err),  32'h0);
            end
        join

        // Back-to-back 0x3C, 0xFF with a late clear
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 5);
        sendFrame(8'h3C, 1'b1, -1, 10*B);
        checkOutput("b2b first data",    32'(DataRx_out),  32'h3C);
        checkOutput("b2b first overrun", 32'(overrun_err), 32'h0);
        sendFrame(8'hFF, 1'b1, -1, 10*B);
        checkOutput("b2b second data",    32'(DataRx_out),  32'hFF);
        checkOutput("b2b second flag",    32'(Rx_flag),     32'h1);
        checkOutput("b2b second overrun", 32'(overrun_err), 32'h1);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("b2b clear flag",    32'(Rx_flag),     32'h0);
        checkOutput("b2b clear overrun", 32'(overrun_err), 32'h0);
        checkOutput("b2b clear ferr",    32'(frame_err),   32'h0);
        applyStimulus(1'b1, 1'b0, 5);

        // Glitch rejection: 4 low clocks
        busy_cnt = 0;
        fork
            begin
                applyStimulus(1'b0, 1'b0, 4);
                applyStimulus(1'b1, 1'b0, 36);
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (rx_busy) busy_cnt++;
                end
            end
        join
        checkOutput("glitch busy cycles", 32'(busy_cnt),   32'd8);
        checkOutput("glitch flag",        32'(Rx_flag),    32'h0);
        checkOutput("glitch ferr",        32'(frame_err),  32'h0);
        checkOutput("glitch data",        32'(DataRx_out), 32'hFF);

        // Framing error on 0x55, then line held low for 40 clocks
        sendFrame(8'h55, 1'b0, -1, 10*B);
        applyStimulus(1'b0, 1'b0, 40);
        checkOutput("ferr set",          32'(frame_err),  32'h1);
        checkOutput("ferr data kept",    32'(DataRx_out), 32'hFF);
        checkOutput("ferr flag",         32'(Rx_flag),    32'h0);
        checkOutput("ferr busy in hold", 32'(rx_busy),    32'h1);
        applyStimulus(1'b1, 1'b0, 20);
        checkOutput("ferr busy after release", 32'(rx_busy),   32'h0);
        checkOutput("ferr no new frame",       32'(Rx_flag),   32'h0);
        checkOutput("ferr still sticky",       32'(frame_err), 32'h1);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("ferr cleared", 32'(frame_err), 32'h0);

        // Clear in the exact cycle of a good stop sample
        sendFrame(8'h12, 1'b1, -1, 10*B);
        checkOutput("pre-collision data",    32'(DataRx_out),  32'h12);
        checkOutput("pre-collision overrun", 32'(overrun_err), 32'h0);
        sendFrame(8'hC3, 1'b1, 2 + H + 9*B, 10*B);
        checkOutput("collision flag",    32'(Rx_flag),     32'h1);
        checkOutput("collision overrun", 32'(overrun_err), 32'h0);
        checkOutput("collision data",    32'(DataRx_out),  32'hC3);

        // Reset during DATA bit 4, then a clean 0x81
        sendFrame(8'h5A, 1'b1, -1, 80);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset data",    32'(DataRx_out),  32'h00);
        checkOutput("async reset flag",    32'(Rx_flag),     32'h0);
        checkOutput("async reset busy",    32'(rx_busy),     32'h0);
        checkOutput("async reset ferr",    32'(frame_err),   32'h0);
        checkOutput("async reset overrun", 32'(overrun_err), 32'h0);
        applyStimulus(1'b1, 1'b0, 3);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 20);
        checkOutput("post-reset flag", 32'(Rx_flag), 32'h0);
        checkOutput("post-reset busy", 32'(rx_busy), 32'h0);
        sendFrame(8'h81, 1'b1, -1, 10*B);
        checkOutput("post-reset data",    32'(DataRx_out),  32'h81);
        checkOutput("post-reset flag2",   32'(Rx_flag),     32'h1);
        checkOutput("post-reset overrun", 32'(overrun_err), 32'h0);
        checkOutput("post-reset ferr",    32'(frame_err),   32'h0);

        applyStimulus(1'b1, 1'b0, 5);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial receive front end for the MIPS SoC. It synchronizes the asynchronous `SerialDataIn` pin into the `clk` domain and detects 8N1 frames using mid-bit sampling. Received bytes go to the core's UART-receive register path as `DataRx_out` with a sticky `Rx_flag`, which the core acknowledges through `rx_clear`. It sits directly between the board pin and `MIPS_new`'s memory-mapped UART data/flag registers.

## Interface
- `CLK_FREQ`, 50000000: `clk` frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `BIT_TICKS`, `CLK_FREQ/BAUD_RATE` (integer division, 434 at defaults): clocks per bit. Must be ≥ 4.
- `HALF_TICKS`, `BIT_TICKS/2` (integer division): clocks from the detected start edge to the start-bit mid-point.
- `clk`, input, 1: system clock. The only clock in the block.
- `reset`, input, 1: asynchronous, active-low reset.
- `SerialDataIn`, input, 1: asynchronous RX line, idle high.
- `rx_clear`, input, 1: one-cycle acknowledge from the core. Clears `Rx_flag`, `overrun_err` and `frame_err`.
- `DataRx_out`, output, 8: last good received byte.
- `Rx_flag`, output, 1: sticky "byte available".
- `frame_err`, output, 1: sticky "stop bit sampled low".
- `overrun_err`, output, 1: sticky "byte completed while `Rx_flag` was still set".
- `rx_busy`, output, 1: high whenever the state is not IDLE.

## Operation
- **Synchronizer:** two flops on `SerialDataIn`, both reset to 1. The FSM only uses `rx_s`, the second flop's output.
- **Counters:**
  - `cnt` is a tick counter with width `clog2(BIT_TICKS)`. It resets to 0 on every state entry and after each sample.
  - `bit_idx` is 3 bits wide.
  - `shreg` is 8 bits and shifts right. Each sample enters at bit 7, so the LSB arrives first.
- **FSM states and transitions:**
  - **IDLE:** if `rx_s`==0, go to START with `cnt`=0.
  - **START:** count up to `HALF_TICKS-1`. At that count:
    - if `rx_s`==0, go to DATA with `bit_idx`=0;
    - otherwise it was a glitch: return to IDLE with no flag change.
  - **DATA:** at `cnt`==`BIT_TICKS-1`, shift `rx_s` into `shreg`.
    - If `bit_idx`==7, go to STOP.
    - Otherwise increment `bit_idx`.
  - **STOP:** at `cnt`==`BIT_TICKS-1`:
    - if `rx_s`==1: load `DataRx_out` from `shreg`, set `Rx_flag`, go to IDLE;
    - if `rx_s`==0: set `frame_err`, leave `DataRx_out` and `Rx_flag` unchanged, go to BREAK.
  - **BREAK:** wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from being re-detected as a start bit.
- **Overrun:** if a good stop bit occurs while `Rx_flag`==1 and `rx_clear`==0:
  - set `overrun_err`;
  - still overwrite `DataRx_out` with the new byte (newest data wins).
- **Simultaneous events:**
  - `rx_clear` in the same cycle as a good stop sample: `Rx_flag` ends at 1, `overrun_err` ends at 0, and the new byte is loaded.
  - `rx_clear` in the same cycle as a bad stop sample: `frame_err` ends at 1.
- `rx_clear` while no flag is set has no effect.
- **Reset (async, any time, including mid-frame):**
  - FSM goes to IDLE, `cnt`=0, `bit_idx`=0, `shreg`=0;
  - `DataRx_out`=0x00; `Rx_flag`, `frame_err`, `overrun_err` and `rx_busy` all 0;
  - synchronizer flops = 1.
  - After release, a partially received frame is discarded. If the line is low at release, reception restarts from START.

## Timing
- All outputs are registered. Nothing is combinational from input to output.
- Let `te` be the first `clk` edge that samples a low `SerialDataIn`. Then:
  - `rx_s` goes low at `te+2`;
  - START is entered at `te+3`;
  - `rx_busy`=1 from `te+3`.
- Sample points, relative to `te`:
  - start check at `te+2+HALF_TICKS`;
  - data bit k at `te+2+HALF_TICKS+(k+1)·BIT_TICKS`, for k = 0..7;
  - stop bit at `te+2+HALF_TICKS+9·BIT_TICKS`.
- `Rx_flag`/`DataRx_out` (or `frame_err`) update in the cycle after the stop sample. `rx_busy` falls in that same cycle on the good-stop path.
- A new start bit is accepted from the first cycle in IDLE. This allows back-to-back frames with a one-bit stop.
- Tolerated baud mismatch: about ±4%, from mid-bit sampling plus the 1-clock synchronizer uncertainty.

## Test plan
- **Good byte:** `BIT_TICKS`=16, `HALF_TICKS`=8. Send frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop).
  - Required: `DataRx_out`=0xA5 and `Rx_flag`=1 exactly at `te+155`, `frame_err`=0, `rx_busy` low from `te+155`.
- **Back-to-back with late clear:** send 0x3C then 0xFF with no idle gap, and no `rx_clear` until after the second frame.
  - Required: after frame 1, `DataRx_out`=0x3C.
  - After frame 2, `DataRx_out`=0xFF, `overrun_err`=1, `Rx_flag`=1.
  - Then pulse `rx_clear`: all three sticky bits go to 0.
- **Glitch rejection:** drive `SerialDataIn` low for 4 clocks, then high.
  - Required: returns to IDLE at the start check; `Rx_flag`, `frame_err` and `DataRx_out` unchanged; `rx_busy` high for exactly `HALF_TICKS` cycles.
- **Framing error:** send 0x55 with the stop bit low, then hold the line low for 40 clocks before releasing it.
  - Required: `frame_err`=1, `DataRx_out` keeps its prior value, FSM stays in BREAK while the line is low, no new frame is detected until after the release.
- **Clear/complete collision:** assert `rx_clear` in the exact cycle of a good stop sample while `Rx_flag`=1.
  - Required: `Rx_flag`=1, `overrun_err`=0, new byte loaded.
- **Reset mid-frame:** assert `reset`=0 during DATA bit 4, release, then send 0x81.
  - Required: all outputs 0 immediately on assertion (asynchronous), no spurious flag afterwards, 0x81 received correctly.
